// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-file geometry and the MEM/WB write-back bundle.
package pipeline_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic              reg_write;
    reg_idx_t          rd;
    logic [DATA_W-1:0] write_data;
  } wb_bundle_t;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port with optional same-cycle write-back bypass.
module reg_read_port
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic [DATA_W-1:0] data
);

  logic              is_zero;
  logic              hit;
  logic [DATA_W-1:0] stored;

  assign stored  = regs[idx];
  assign is_zero = (idx == ADDR_W'(REG_ZERO));
  // Single index compare ahead of a 2:1 mux keeps the bypass off the storage mux path.
  assign hit     = (BYPASS != 0) && wb_reg_write && (wb_rd == idx);
  assign data    = is_zero ? '0 : (hit ? wb_write_data : stored);

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file: write-back commit, two bypassed read ports, debug read, commit counter.
module reg_file_wb
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WB_RegWrite,
  input  logic [ADDR_W-1:0] WB_Rd,
  input  logic [DATA_W-1:0] WB_write_data,
  input  logic [ADDR_W-1:0] ID_Rs,
  input  logic [ADDR_W-1:0] ID_Rt,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       commit_count
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] mem  [1:NREG-1];
  logic [DATA_W-1:0] view [NREG];
  logic [31:0]       count_q;
  logic              commit;

  assign commit = WB_RegWrite && (WB_Rd != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[WB_Rd] <= WB_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (commit && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  // Register 0 has no storage; the view presents it as a constant zero.
  assign view[0] = '0;
  for (genvar g = 1; g < NREG; g++) begin : g_view
    assign view[g] = mem[g];
  end

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rs (
    .idx           (ID_Rs),
    .regs          (view),
    .wb_reg_write  (WB_RegWrite),
    .wb_rd         (WB_Rd),
    .wb_write_data (WB_write_data),
    .data          (rs_data)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rt (
    .idx           (ID_Rt),
    .regs          (view),
    .wb_reg_write  (WB_RegWrite),
    .wb_rd         (WB_Rd),
    .wb_write_data (WB_write_data),
    .data          (rt_data)
  );

  assign dbg_data     = view[dbg_addr];
  assign commit_count = count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: bypassing and non-bypassing instances checked against an array model.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  rs = '0, rt = '0, dbg = '0;
  logic [31:0] rs_b, rt_b, dbg_b, cnt_b;
  logic [31:0] rs_n, rt_n, dbg_n, cnt_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] m_mem [32];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .WB_RegWrite(we), .WB_Rd(rd), .WB_write_data(wdata),
    .ID_Rs(rs), .ID_Rt(rt), .rs_data(rs_b), .rt_data(rt_b),
    .dbg_addr(dbg), .dbg_data(dbg_b), .commit_count(cnt_b)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .WB_RegWrite(we), .WB_Rd(rd), .WB_write_data(wdata),
    .ID_Rs(rs), .ID_Rt(rt), .rs_data(rs_n), .rt_data(rt_n),
    .dbg_addr(dbg), .dbg_data(dbg_n), .commit_count(cnt_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: index 0 is zero, a pending write to the same index shows through when bypassing.
  function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && we && rd == idx) return wdata;
    return m_mem[idx];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_cnt = '0;
  end

  always @(negedge reset) begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_cnt = '0;
  end

  always @(posedge clk) begin
    if (reset && we && rd != 5'd0) begin
      m_mem[rd] = wdata;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rs_byp",  rs_b,  m_read(rs, 1'b1));
      chk("rt_byp",  rt_b,  m_read(rt, 1'b1));
      chk("dbg_byp", dbg_b, m_read(dbg, 1'b0));
      chk("cnt_byp", cnt_b, m_cnt);
      chk("rs_nb",   rs_n,  m_read(rs, 1'b0));
      chk("rt_nb",   rt_n,  m_read(rt, 1'b0));
      chk("dbg_nb",  dbg_n, m_read(dbg, 1'b0));
      chk("cnt_nb",  cnt_n, m_cnt);
    end
  end

  // Apply a vector just after a rising edge so it is stable across the next edge.
  task automatic drive(input logic w, input logic [4:0] d, input logic [31:0] v,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] g);
    we = w; rd = d; wdata = v; rs = a; rt = b; dbg = g;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  localparam logic [4:0]  VRD [8] = '{5'd1, 5'd2, 5'd30, 5'd2, 5'd0, 5'd17, 5'd1, 5'd30};
  localparam logic [31:0] VDT [8] = '{32'h1111_0001, 32'h2222_0002, 32'hCAFE_F00D, 32'h0BAD_0002,
                                      32'hFFFF_FFFF, 32'h0000_0017, 32'h8000_0000, 32'h7FFF_FFFF};
  localparam logic [4:0]  VRS [8] = '{5'd1, 5'd1, 5'd30, 5'd2, 5'd0, 5'd16, 5'd1, 5'd2};
  localparam logic [4:0]  VRT [8] = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd17, 5'd17, 5'd30, 5'd30};

  initial begin
    #2 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (2) step();
    chk("reset_count", cnt_b, 32'd0);
    @(negedge clk) reset = 1'b1;
    step();

    drive(1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd5); step();
    drive(1, 5'd31, 32'h1234_5678, 5'd5, 5'd31, 5'd31); step();
    drive(0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd5);
    @(negedge clk);
    chk("lit_r5", dbg_b, 32'hDEAD_BEEF);
    chk("lit_cnt2", cnt_b, 32'd2);
    dbg = 5'd31; #1;
    chk("lit_r31", dbg_b, 32'h1234_5678);
    step();

    drive(1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    @(negedge clk) chk("lit_zero_pre", rs_b, 32'd0);
    step();
    drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk) begin chk("lit_zero_post", rs_b, 32'd0); chk("lit_zero_cnt", cnt_b, 32'd2); end
    step();

    drive(1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd7); step();
    drive(1, 5'd7, 32'h2, 5'd7, 5'd7, 5'd7);
    @(negedge clk) begin
      chk("lit_byp_rs", rs_b, 32'h2);
      chk("lit_byp_rt", rt_b, 32'h2);
      chk("lit_byp_dbg", dbg_b, 32'h1);
      chk("lit_nb_rs_pre", rs_n, 32'h1);
    end
    step();
    drive(0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    @(negedge clk) chk("lit_nb_rs_post", rs_n, 32'h2);
    step();

    drive(1, 5'd9, 32'h55, 5'd0, 5'd0, 5'd9); step();
    drive(0, 5'd9, 32'hAAAA_5555, 5'd9, 5'd9, 5'd9);
    @(negedge clk) chk("lit_dis_rs", rs_b, 32'h55);
    step();
    drive(0, 5'd0, 32'd0, 5'd9, 5'd0, 5'd9);
    @(negedge clk) begin chk("lit_dis_dbg", dbg_b, 32'h55); chk("lit_dis_cnt", cnt_b, 32'd5); end
    step();

    for (int i = 0; i < 8; i++) begin
      drive(1, VRD[i], VDT[i], VRS[i], VRT[i], VRD[i]);
      step();
    end
    drive(0, 5'd0, 32'd0, 5'd30, 5'd2, 5'd1); step();
    chk("lit_r30", rs_b, 32'h7FFF_FFFF);
    chk("lit_r2", rt_b, 32'h0BAD_0002);
    chk("lit_r1", dbg_b, 32'h8000_0000);

    // Asynchronous clear: checked between edges, no clock needed.
    drive(0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd0);
    #2 reset = 1'b0;
    #1;
    chk("rst_rs", rs_b, 32'd0);
    chk("rst_rt", rt_b, 32'd0);
    chk("rst_cnt", cnt_b, 32'd0);
    chk("rst_cnt_nb", cnt_n, 32'd0);
    for (int i = 1; i < 32; i++) begin
      dbg = 5'(i); #0.1;
      chk("rst_reg", dbg_b, 32'd0);
    end
    step();
    drive(1, 5'd3, 32'h77, 5'd3, 5'd3, 5'd3);
    @(negedge clk) begin chk("rst_byp", rs_b, 32'h77); chk("rst_nb", rs_n, 32'd0); end
    step();
    drive(0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3);
    @(negedge clk) chk("rst_nowrite", dbg_b, 32'd0);
    reset = 1'b1;
    step();

    drive(1, 5'd4, 32'h44, 5'd4, 5'd4, 5'd4); step();
    drive(0, 5'd0, 32'd0, 5'd4, 5'd4, 5'd4);
    force dut.count_q = 32'hFFFF_FFFE;
    force dut_nb.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    release dut_nb.count_q;
    m_cnt = 32'hFFFF_FFFE;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(10 + i), 32'(i + 100), 5'd4, 5'd0, 5'(10 + i));
      step();
      chk("sat_cnt", cnt_b, 32'hFFFF_FFFF);
    end
    drive(0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) step();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
